// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SCL generator FSM states, default phase lengths,
// and a small max helper used to size the phase counter.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } scl_state_t;

  localparam int SCL_LOW_CYC_DEF  = 2;
  localparam int SCL_HIGH_CYC_DEF = 2;

  function automatic int i2c_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clock_generator.sv
// Purpose : generates a registered I2C SCL with programmable low/high phase
//           lengths, plus one-cycle fall/rise strobes aligned with SCL edges.
// Latency : SCL falls on the first core clock edge that samples clk_en_i=1.
// Backpressure: none; dropping clk_en_i parks SCL high without truncating
//           a low phase (only reset may cut a low phase short).
// Ports   : i2c_core_clk_i / i2c_core_rst_i (async, active-high), clk_en_i,
//           i2c_scl_o, scl_fall_o, scl_rise_o, busy_o.
module clock_generator
  import i2c_pkg::*;
#(
  parameter int SCL_LOW_CYC  = SCL_LOW_CYC_DEF,
  parameter int SCL_HIGH_CYC = SCL_HIGH_CYC_DEF
) (
  input  logic i2c_core_clk_i,
  input  logic i2c_core_rst_i,
  input  logic clk_en_i,
  output logic i2c_scl_o,
  output logic scl_fall_o,
  output logic scl_rise_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(i2c_max(SCL_LOW_CYC, SCL_HIGH_CYC) + 1);

  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(SCL_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(SCL_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (SCL_LOW_CYC < 1 || SCL_LOW_CYC > 65535) begin : g_bad_low
    $error("clock_generator: SCL_LOW_CYC must be in 1..65535");
  end
  if (SCL_HIGH_CYC < 1 || SCL_HIGH_CYC > 65535) begin : g_bad_high
    $error("clock_generator: SCL_HIGH_CYC must be in 1..65535");
  end

  scl_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             scl_q, scl_d;
  logic             fall_q, fall_d;
  logic             rise_q, rise_d;

  // State register. SCL and strobes are registered alongside the state so
  // the pin never sees a combinational path from clk_en_i.
  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      scl_q   <= 1'b1;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scl_q   <= scl_d;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
    end
  end

  // Next-state logic. The LOW phase always runs its full count; clk_en_i is
  // only consulted at its final cycle, so a late re-enable resumes toggling.
  // HIGH, by contrast, may be abandoned at any edge since SCL is already high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clk_en_i) begin
          state_d = ST_LOW;
          cnt_d   = LOW_LOAD;
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (clk_en_i) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!clk_en_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: SCL is low only in LOW; strobes mark entry to / exit from
  // LOW, so fall and rise can never coincide.
  always_comb begin
    scl_d  = (state_d != ST_LOW);
    fall_d = (state_q != ST_LOW) && (state_d == ST_LOW);
    rise_d = (state_q == ST_LOW) && (state_d != ST_LOW);
  end

  assign i2c_scl_o  = scl_q;
  assign scl_fall_o = fall_q;
  assign scl_rise_o = rise_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_generator.sv
module tb_clock_generator;

  logic clk;
  logic rst;
  logic en_a, en_b;
  logic scl_a, fall_a, rise_a, busy_a;
  logic scl_b, fall_b, rise_b, busy_b;

  int checks;
  int failures;

  clock_generator dut_a (
    .i2c_core_clk_i(clk),
    .i2c_core_rst_i(rst),
    .clk_en_i      (en_a),
    .i2c_scl_o     (scl_a),
    .scl_fall_o    (fall_a),
    .scl_rise_o    (rise_a),
    .busy_o        (busy_a)
  );

  clock_generator #(.SCL_LOW_CYC(5), .SCL_HIGH_CYC(3)) dut_b (
    .i2c_core_clk_i(clk),
    .i2c_core_rst_i(rst),
    .clk_en_i      (en_b),
    .i2c_scl_o     (scl_b),
    .scl_fall_o    (fall_b),
    .scl_rise_o    (rise_b),
    .busy_o        (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  // {scl, fall, rise, busy}
  function automatic logic [3:0] obs_a();
    return {scl_a, fall_a, rise_a, busy_a};
  endfunction

  function automatic logic [3:0] obs_b();
    return {scl_b, fall_b, rise_b, busy_b};
  endfunction

  task automatic test_reset();
    en_a = 1'b0;
    en_b = 1'b0;
    rst  = 1'b1;
    #3;
    checks++;
    if (obs_a() !== 4'b1000) begin
      failures++;
      $display("FAIL reset_a: got %b expected 1000", obs_a());
    end
    checks++;
    if (obs_b() !== 4'b1000) begin
      failures++;
      $display("FAIL reset_b: got %b expected 1000", obs_b());
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs_a() !== 4'b1000) begin
        failures++;
        $display("FAIL idle_disabled cyc %0d: got %b expected 1000", i, obs_a());
      end
    end
  endtask

  task automatic test_toggle();
    int nfall, nrise;
    logic [3:0] exp;
    nfall = 0;
    nrise = 0;
    do_reset();
    en_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      case (i % 4)
        0: exp = 4'b0101;
        1: exp = 4'b0001;
        2: exp = 4'b1011;
        default: exp = 4'b1001;
      endcase
      if (fall_a) nfall++;
      if (rise_a) nrise++;
      checks++;
      if (obs_a() !== exp) begin
        failures++;
        $display("FAIL toggle cyc %0d: got %b expected %b", i, obs_a(), exp);
      end
    end
    checks++;
    if (nfall !== 4 || nrise !== 4) begin
      failures++;
      $display("FAIL strobe_count: got fall=%0d rise=%0d expected 4/4", nfall, nrise);
    end
    en_a = 1'b0;
    tick();
  endtask

  task automatic test_drop_low();
    logic [3:0] exp_seq [3] = '{4'b0101, 4'b0001, 4'b1010};
    do_reset();
    en_a = 1'b1;
    tick();
    checks++;
    if (obs_a() !== exp_seq[0]) begin
      failures++;
      $display("FAIL drop_low enter: got %b expected %b", obs_a(), exp_seq[0]);
    end
    en_a = 1'b0;
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if (obs_a() !== exp_seq[i]) begin
        failures++;
        $display("FAIL drop_low cyc %0d: got %b expected %b", i, obs_a(), exp_seq[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_a() !== 4'b1000) begin
        failures++;
        $display("FAIL drop_low parked cyc %0d: got %b expected 1000", i, obs_a());
      end
    end
  endtask

  task automatic test_drop_high();
    do_reset();
    en_a = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (obs_a() !== 4'b1011) begin
      failures++;
      $display("FAIL drop_high rise: got %b expected 1011", obs_a());
    end
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_a() !== 4'b1000) begin
        failures++;
        $display("FAIL drop_high cyc %0d: got %b expected 1000", i, obs_a());
      end
    end
  endtask

  task automatic test_resume();
    logic [3:0] exp_seq [4] = '{4'b0001, 4'b1011, 4'b1001, 4'b0101};
    do_reset();
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    tick();
    checks++;
    if (obs_a() !== exp_seq[0]) begin
      failures++;
      $display("FAIL resume low2: got %b expected %b", obs_a(), exp_seq[0]);
    end
    en_a = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (obs_a() !== exp_seq[i]) begin
        failures++;
        $display("FAIL resume cyc %0d: got %b expected %b", i, obs_a(), exp_seq[i]);
      end
    end
    en_a = 1'b0;
    tick();
  endtask

  task automatic test_low5_high3();
    logic [3:0] exp;
    do_reset();
    en_b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      case (i % 8)
        0: exp = 4'b0101;
        1, 2, 3, 4: exp = 4'b0001;
        5: exp = 4'b1011;
        default: exp = 4'b1001;
      endcase
      checks++;
      if (obs_b() !== exp) begin
        failures++;
        $display("FAIL low5_high3 cyc %0d: got %b expected %b", i, obs_b(), exp);
      end
    end
    en_b = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    en_a = 1'b1;
    tick();
    checks++;
    if (obs_a() !== 4'b0101) begin
      failures++;
      $display("FAIL async_rst pre: got %b expected 0101", obs_a());
    end
    rst = 1'b1;
    #2;
    checks++;
    if (obs_a() !== 4'b1000) begin
      failures++;
      $display("FAIL async_rst mid_low: got %b expected 1000", obs_a());
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs_a() !== 4'b0101) begin
      failures++;
      $display("FAIL async_rst first_fall: got %b expected 0101", obs_a());
    end
    en_a = 1'b0;
    tick();
    tick();
    checks++;
    if (obs_a() !== 4'b1010) begin
      failures++;
      $display("FAIL async_rst recover: got %b expected 1010", obs_a());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    en_a     = 1'b0;
    en_b     = 1'b0;
    test_reset();
    test_toggle();
    test_drop_low();
    test_drop_high();
    test_resume();
    test_low5_high3();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_generator.md
CLOCK_GENERATOR -- requirements
Module: clock_generator

Interface
REQ-001 SHALL have parameter SCL_LOW_CYC, default 2, meaning SCL low-phase length in core clock cycles (legal range 1..65535).
REQ-002 SHALL have parameter SCL_HIGH_CYC, default 2, meaning SCL high-phase length in core clock cycles (legal range 1..65535).
REQ-003 SHALL have port i2c_core_clk_i, input, 1 bit: the single i2c core clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port i2c_core_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port clk_en_i, input, 1 bit: enables SCL toggling while high.
REQ-006 SHALL have port i2c_scl_o, output, 1 bit: generated SCL, registered, idle high.
REQ-007 SHALL have port scl_fall_o, output, 1 bit: one-cycle strobe asserted in the same cycle i2c_scl_o first reads 0.
REQ-008 SHALL have port scl_rise_o, output, 1 bit: one-cycle strobe asserted in the same cycle i2c_scl_o first reads 1 after a low phase.
REQ-009 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, LOW, HIGH; i2c_scl_o SHALL be 0 in LOW and 1 in IDLE and HIGH.
REQ-011 SHALL use a down-counter CNT_W = clog2(max(SCL_LOW_CYC, SCL_HIGH_CYC)+1) bits wide; it never wraps below 0.
REQ-012 IDLE with clk_en_i sampled 1 SHALL enter LOW at that edge, loading the counter with SCL_LOW_CYC-1 and pulsing scl_fall_o.
REQ-013 LOW SHALL last exactly SCL_LOW_CYC cycles; at counter 0 SHALL enter HIGH, load SCL_HIGH_CYC-1, and pulse scl_rise_o.
REQ-014 HIGH with counter 0 and clk_en_i=1 SHALL enter LOW, load SCL_LOW_CYC-1, and pulse scl_fall_o; otherwise it SHALL decrement.
REQ-015 clk_en_i sampled 0 in HIGH SHALL enter IDLE at that edge, leaving SCL high with no extra edge.
REQ-016 clk_en_i sampled 0 in LOW SHALL NOT shorten the phase; LOW completes its full count, then enters IDLE (not HIGH) with scl_rise_o pulsed.
REQ-017 clk_en_i reasserted during a terminating LOW phase SHALL resume normal toggling: LOW -> HIGH.
REQ-018 With clk_en_i held 1, the SCL period SHALL be exactly SCL_LOW_CYC+SCL_HIGH_CYC core cycles with no glitches.
REQ-019 scl_fall_o and scl_rise_o SHALL never be asserted in the same cycle, and each SHALL be high for exactly one cycle per edge.
REQ-020 i2c_scl_o SHALL be driven directly from a flip-flop, with no combinational path from clk_en_i.

Reset
REQ-021 Asserting i2c_core_rst_i SHALL immediately force state IDLE, counter 0, i2c_scl_o=1, scl_fall_o=0, scl_rise_o=0, busy_o=0.
REQ-022 Reset mid-LOW SHALL return SCL high immediately; this is the only permitted truncated phase.
REQ-023 After reset deasserts, the first SCL fall SHALL occur at the first rising edge where clk_en_i is sampled 1.

Structure
REQ-024 SHALL place the FSM state typedef (IDLE/LOW/HIGH) and default timing constants (2, 2) in shared package i2c_pkg.
REQ-025 SHALL be a single module with no sub-modules.
REQ-026 SHALL include elaboration-time checks that reject SCL_LOW_CYC < 1 or SCL_HIGH_CYC < 1.

Verification
REQ-027 Reset, then clk_en_i=0 for 12 cycles -> i2c_scl_o=1, all strobes 0, busy_o=0 throughout.
REQ-028 Defaults, 10 ns clock, clk_en_i=1 for 16 cycles -> SCL pattern 0,0,1,1 repeating (period 40 ns); exactly 4 scl_fall_o pulses and 4 scl_rise_o pulses.
REQ-029 Drop clk_en_i on the first LOW cycle -> SCL stays low for a total of 2 cycles, rises once, then stays at 1 with busy_o=0.
REQ-030 Drop clk_en_i during HIGH -> next state IDLE, SCL remains 1, no further strobes.
REQ-031 SCL_LOW_CYC=5, SCL_HIGH_CYC=3, enable held -> SCL low 5 cycles and high 3 cycles, repeating.
REQ-032 Assert i2c_core_rst_i asynchronously mid-LOW -> SCL goes 1 before the next clock edge; all strobes 0.
